// File: rtl/bip_control_unit.sv
// BIP control path: program counter, instruction decoder and IDLE/RUN/HALT FSM.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   start_bip             - start from IDLE, restart from HALT (ignored in RUN)
//   opcode, operand       - instruction from program memory at addr (operand = branch target)
//   acc_zero              - accumulator-is-zero flag from the datapath
//   addr                  - program counter / program memory address
//   sel_a, sel_b, wr_acc, op, wr_ram, rd_ram - datapath controls, decoded from opcode
//                           combinationally and forced to 0 outside RUN
//   halted                - high while in HALT
//   instr_count           - saturating retired-instruction counter
module bip_control_unit #(
  parameter int unsigned AB      = 11,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned RST_VEC = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_bip,
  input  logic [4:0]       opcode,
  input  logic [AB-1:0]    operand,
  input  logic             acc_zero,
  output logic [AB-1:0]    addr,
  output logic [1:0]       sel_a,
  output logic             sel_b,
  output logic             wr_acc,
  output logic             op,
  output logic             wr_ram,
  output logic             rd_ram,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_JMP  = 5'b01000;
  localparam logic [4:0] OP_BEQ  = 5'b01001;
  localparam logic [4:0] OP_BNE  = 5'b01010;

  localparam logic [AB-1:0]    RST_ADDR = AB'(RST_VEC);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } bipState_t;

  bipState_t         state;
  bipState_t         stateNext;
  logic [AB-1:0]     addrNext;
  logic [AB-1:0]     addrInc;
  logic [CNT_W-1:0]  countNext;

  assign addrInc = addr + AB'(1);  // wraps modulo 2^AB
  assign halted  = (state == HALT);

  // State, PC and retired counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= RST_ADDR;
      instr_count <= '0;
    end else begin
      state       <= stateNext;
      addr        <= addrNext;
      instr_count <= countNext;
    end
  end

  // Next-state, PC update and decode (decode only active in RUN)
  always_comb begin
    stateNext = state;
    addrNext  = addr;
    countNext = instr_count;
    sel_a     = 2'b00;
    sel_b     = 1'b0;
    wr_acc    = 1'b0;
    op        = 1'b0;
    wr_ram    = 1'b0;
    rd_ram    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_bip) stateNext = RUN;
      end

      HALT: begin
        if (start_bip) begin
          stateNext = RUN;
          addrNext  = RST_ADDR;
          countNext = '0;
        end
      end

      RUN: begin
        if (opcode == OP_HLT) begin
          stateNext = HALT;
        end else begin
          // Saturate rather than wrap
          if (instr_count != CNT_MAX) countNext = instr_count + CNT_W'(1);
          case (opcode)
            OP_JMP:  addrNext = operand;
            OP_BEQ:  addrNext = acc_zero  ? operand : addrInc;
            OP_BNE:  addrNext = !acc_zero ? operand : addrInc;
            default: addrNext = addrInc;
          endcase
        end

        case (opcode)
          OP_STO:  wr_ram = 1'b1;
          OP_LD:   begin wr_acc = 1'b1; rd_ram = 1'b1; end
          OP_LDI:  begin sel_a = 2'b01; wr_acc = 1'b1; end
          OP_ADD:  begin sel_a = 2'b10; wr_acc = 1'b1; rd_ram = 1'b1; end
          OP_ADDI: begin sel_a = 2'b10; sel_b = 1'b1; wr_acc = 1'b1; end
          OP_SUB:  begin sel_a = 2'b10; wr_acc = 1'b1; op = 1'b1; rd_ram = 1'b1; end
          OP_SUBI: begin sel_a = 2'b10; sel_b = 1'b1; wr_acc = 1'b1; op = 1'b1; end
          default: ;
        endcase
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: a default instance (AB=11, CNT_W=16, RST_VEC=0) and a
// narrow instance (AB=4, CNT_W=4, RST_VEC=3) share stimulus and are checked each cycle
// against an arithmetic reference model.
module tb_bip_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_bip;
  logic [4:0]  opcode;
  logic [10:0] operand;
  logic        acc_zero;

  logic [10:0] addrA;
  logic [1:0]  selAA;
  logic        selBA, wrAccA, opA, wrRamA, rdRamA, haltedA;
  logic [15:0] countA;

  logic [3:0]  addrB;
  logic [1:0]  selAB;
  logic        selBB, wrAccB, opB, wrRamB, rdRamB, haltedB;
  logic [3:0]  countB;
  logic [3:0]  operandB;

  assign operandB = operand[3:0];

  always #5 clk = ~clk;

  bip_control_unit #(.AB(11), .CNT_W(16), .RST_VEC(0)) dutA (
    .clk(clk), .rst(rst), .start_bip(start_bip), .opcode(opcode), .operand(operand),
    .acc_zero(acc_zero), .addr(addrA), .sel_a(selAA), .sel_b(selBA), .wr_acc(wrAccA),
    .op(opA), .wr_ram(wrRamA), .rd_ram(rdRamA), .halted(haltedA), .instr_count(countA)
  );

  bip_control_unit #(.AB(4), .CNT_W(4), .RST_VEC(3)) dutB (
    .clk(clk), .rst(rst), .start_bip(start_bip), .opcode(opcode), .operand(operandB),
    .acc_zero(acc_zero), .addr(addrB), .sel_a(selAB), .sel_b(selBB), .wr_acc(wrAccB),
    .op(opB), .wr_ram(wrRamB), .rd_ram(rdRamB), .halted(haltedB), .instr_count(countB)
  );

  // Reference model: running/halted flags, PC and counter as plain integers
  int unsigned nAsserts = 0;
  int unsigned nFails   = 0;
  bit          mRun, mHalt;
  int          mAddr [2];
  int          mCnt  [2];
  int          abW   [2] = '{11, 4};
  int          cntW  [2] = '{16, 4};
  int          rstVec[2] = '{0, 3};

  // Expected controls {sel_a, sel_b, wr_acc, op, wr_ram, rd_ram} from the decode table
  function automatic logic [6:0] expDec(input int opc);
    case (opc)
      1:       return 7'b00_0_0_0_1_0;  // STO
      2:       return 7'b00_0_1_0_0_1;  // LD
      3:       return 7'b01_0_1_0_0_0;  // LDI
      4:       return 7'b10_0_1_0_0_1;  // ADD
      5:       return 7'b10_1_1_0_0_0;  // ADDI
      6:       return 7'b10_0_1_1_0_1;  // SUB
      7:       return 7'b10_1_1_1_0_0;  // SUBI
      default: return 7'b00_0_0_0_0_0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nAsserts++;
    assert (obs === expv) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic modelReset();
    mRun  = 1'b0;
    mHalt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mAddr[i] = rstVec[i];
      mCnt[i]  = 0;
    end
  endtask

  task automatic modelEdge(input bit r, input bit s, input int opc, input int opnd, input bit az);
    bit taken;
    int modulus;
    if (r) begin
      modelReset();
    end else if (!mRun && !mHalt) begin
      if (s) mRun = 1'b1;
    end else if (mHalt) begin
      if (s) begin
        mHalt = 1'b0;
        mRun  = 1'b1;
        for (int i = 0; i < 2; i++) begin
          mAddr[i] = rstVec[i];
          mCnt[i]  = 0;
        end
      end
    end else if (opc == 0) begin
      mRun  = 1'b0;
      mHalt = 1'b1;
    end else begin
      taken = (opc == 8) || (opc == 9 && az) || (opc == 10 && !az);
      for (int i = 0; i < 2; i++) begin
        modulus  = 1 << abW[i];
        mAddr[i] = taken ? (opnd % modulus) : ((mAddr[i] + 1) % modulus);
        if (mCnt[i] < (1 << cntW[i]) - 1) mCnt[i] = mCnt[i] + 1;
      end
    end
  endtask

  task automatic checkAll();
    logic [6:0] dec;
    dec = mRun ? expDec(int'(opcode)) : 7'd0;
    chk("addrA",   32'(addrA),   32'(mAddr[0]));
    chk("countA",  32'(countA),  32'(mCnt[0]));
    chk("haltedA", 32'(haltedA), 32'(mHalt));
    chk("ctrlA",   32'({selAA, selBA, wrAccA, opA, wrRamA, rdRamA}), 32'(dec));
    chk("addrB",   32'(addrB),   32'(mAddr[1]));
    chk("countB",  32'(countB),  32'(mCnt[1]));
    chk("haltedB", 32'(haltedB), 32'(mHalt));
    chk("ctrlB",   32'({selAB, selBB, wrAccB, opB, wrRamB, rdRamB}), 32'(dec));
  endtask

  // Apply inputs mid-cycle, check outputs, then advance model and DUT together
  task automatic step(input bit r, input bit s, input logic [4:0] opc,
                      input logic [10:0] opnd, input bit az);
    rst       = r;
    start_bip = s;
    opcode    = opc;
    operand   = opnd;
    acc_zero  = az;
    #1;
    checkAll();
    @(posedge clk);
    modelEdge(r, s, int'(opc), int'(opnd), az);
    @(negedge clk);
  endtask

  initial begin
    bit          r, s, az;
    logic [4:0]  opc;
    logic [10:0] opnd;

    // First reset cycle brings the DUT out of X; second one is checked
    rst = 1'b1; start_bip = 1'b0; opcode = 5'd0; operand = 11'd0; acc_zero = 1'b0;
    @(posedge clk);
    modelReset();
    @(negedge clk);
    step(1, 0, 5'h00, 11'h000, 0);

    // Start: the opcode present in the transition cycle must not execute
    step(0, 1, 5'h03, 11'h005, 0);
    step(0, 0, 5'h03, 11'h005, 0);  // LDI 5
    step(0, 0, 5'h05, 11'h003, 0);  // ADDI 3
    step(0, 0, 5'h01, 11'h007, 0);  // STO 7
    step(0, 0, 5'h00, 11'h000, 0);  // HLT
    step(0, 0, 5'h00, 11'h000, 0);
    step(0, 0, 5'h04, 11'h000, 0);  // in HALT, controls stay 0

    // Restart from HALT, then branches
    step(0, 1, 5'h1f, 11'h000, 0);
    step(0, 0, 5'h09, 11'h040, 1);  // BEQ taken
    step(0, 0, 5'h09, 11'h100, 0);  // BEQ not taken
    step(0, 0, 5'h0a, 11'h020, 0);  // BNE taken
    step(0, 0, 5'h0a, 11'h030, 1);  // BNE not taken
    step(0, 0, 5'h08, 11'h7ff, 0);  // JMP to top of address space
    step(0, 0, 5'h04, 11'h000, 0);  // ADD wraps PC to 0
    step(0, 0, 5'h1f, 11'h000, 0);  // illegal opcode acts as NOP
    step(0, 1, 5'h02, 11'h000, 0);  // start in RUN is ignored
    step(0, 0, 5'h06, 11'h000, 0);
    step(1, 0, 5'h07, 11'h000, 0);  // reset while running
    step(0, 0, 5'h02, 11'h000, 0);

    // Counter saturation on the narrow instance
    step(0, 1, 5'h03, 11'h000, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 5'h03, 11'(i), 0);

    // start_bip held high across HLT: one cycle in HALT, then restart
    step(0, 1, 5'h00, 11'h000, 0);
    step(0, 1, 5'h00, 11'h000, 0);
    step(0, 1, 5'h05, 11'h000, 0);
    step(0, 1, 5'h05, 11'h000, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r    = ($urandom_range(0, 59) == 0);
      s    = ($urandom_range(0, 3) == 0);
      az   = 1'($urandom_range(0, 1));
      opc  = ($urandom_range(0, 11) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      opnd = 11'($urandom);
      step(r, s, opc, opnd, az);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
